// File: rtl/ysyx_23060072_mem_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/LSU memory arbiter.
package ysyx_23060072_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/ysyx_23060072_arb_pick.sv
// Combinational IF/LSU priority pick with a saturating starvation counter
// that lets a waiting fetch win after IF_STARVE_MAX contested LSU wins.
module ysyx_23060072_arb_pick
  import ysyx_23060072_mem_arbiter_pkg::*;
#(
  parameter int IF_STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic if_flush,
  input  logic lsu_req,
  output logic if_gnt,
  output logic lsu_gnt
);

  localparam logic [3:0] STARVE_MAX = 4'(IF_STARVE_MAX);

  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;
  logic       if_cand;

  always_comb begin
    if_cand = if_req && !if_flush;
    if_gnt  = 1'b0;
    lsu_gnt = 1'b0;
    if (arb_en) begin
      if (if_cand && lsu_req) begin
        if (starve_cnt_reg == STARVE_MAX) if_gnt = 1'b1;
        else                              lsu_gnt = 1'b1;
      end else if (if_cand) begin
        if_gnt = 1'b1;
      end else if (lsu_req) begin
        lsu_gnt = 1'b1;
      end
    end
  end

  // Raw if_req (not the flushed candidate) counts as a waiting fetch.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (if_gnt) begin
      starve_cnt_next = 4'd0;
    end else if (lsu_gnt) begin
      if (!if_req)                           starve_cnt_next = 4'd0;
      else if (starve_cnt_reg != STARVE_MAX) starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_reg <= 4'd0;
    else     starve_cnt_reg <= starve_cnt_next;
  end

endmodule

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU; one
// transaction in flight, LSU-first with a starvation guard for fetch.
module ysyx_23060072_mem_arbiter
  import ysyx_23060072_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int IF_STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  arb_state_t          state_reg, state_next;
  arb_owner_t          owner_reg;
  logic                drop_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W/8-1:0] wstrb_reg;
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [DATA_W-1:0]   lsu_rdata_reg;
  logic                arb_en, if_gnt, lsu_gnt;
  logic                resp_fire, if_deliver, lsu_deliver;

  // Grants are combinational, so gate them with rst to keep outputs quiet in reset.
  assign arb_en = (state_reg == IDLE) && !rst;

  ysyx_23060072_arb_pick #(
    .IF_STARVE_MAX(IF_STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .if_req  (if_req_i),
    .if_flush(if_flush_i),
    .lsu_req (lsu_req_i),
    .if_gnt  (if_gnt),
    .lsu_gnt (lsu_gnt)
  );

  assign resp_fire   = (state_reg == RESP) && mem_rvalid_i;
  assign if_deliver  = resp_fire && (owner_reg == OWN_IF) && !drop_reg && !if_flush_i;
  assign lsu_deliver = resp_fire && (owner_reg == OWN_LSU);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (if_gnt || lsu_gnt) state_next = REQ;
      REQ:     if (mem_ready_i)       state_next = RESP;
      RESP:    if (mem_rvalid_i)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_NONE;
      drop_reg      <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      if_rdata_reg  <= '0;
      lsu_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (lsu_gnt) begin
        owner_reg <= OWN_LSU;
        we_reg    <= lsu_we_i;
        addr_reg  <= lsu_addr_i;
        wdata_reg <= lsu_wdata_i;
        wstrb_reg <= lsu_wstrb_i;
      end else if (if_gnt) begin
        owner_reg <= OWN_IF;
        we_reg    <= 1'b0;
        addr_reg  <= if_addr_i;
        wdata_reg <= '0;
        wstrb_reg <= '0;
      end else if (resp_fire) begin
        owner_reg <= OWN_NONE;
      end
      // A redirected fetch still completes downstream; only its response is hidden.
      if (resp_fire)
        drop_reg <= 1'b0;
      else if (state_reg != IDLE && owner_reg == OWN_IF && if_flush_i)
        drop_reg <= 1'b1;
      if (if_deliver)  if_rdata_reg  <= mem_rdata_i;
      if (lsu_deliver) lsu_rdata_reg <= mem_rdata_i;
    end
  end

  assign if_gnt_o     = if_gnt;
  assign lsu_gnt_o    = lsu_gnt;
  assign if_rvalid_o  = if_deliver;
  assign lsu_rvalid_o = lsu_deliver;
  assign if_rdata_o   = if_deliver ? mem_rdata_i : if_rdata_reg;
  assign lsu_rdata_o  = lsu_deliver ? mem_rdata_i : lsu_rdata_reg;
  assign mem_req_o    = (state_reg == REQ);
  assign mem_we_o     = we_reg;
  assign mem_addr_o   = addr_reg;
  assign mem_wdata_o  = wdata_reg;
  assign mem_wstrb_o  = wstrb_reg;

`ifndef SYNTHESIS
  a_rvalid_only_in_resp: assert property (@(posedge clk) disable iff (rst)
    mem_rvalid_i |-> (state_reg == RESP));
`endif

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Bench for the fetch/LSU memory arbiter: a memory model with latency and
// backpressure, a response scoreboard, an arbitration table and corner sequences.
module tb_ysyx_23060072_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [3:0]  lsu_wstrb_i;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wstrb_o;

  always #5 clk = ~clk;

  ysyx_23060072_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } exp_t;
  exp_t sb_if[$];
  exp_t sb_lsu[$];

  int          resp_lat  = 2;
  int          stall_cnt = 0;
  int          lat_cnt   = 0;
  bit          pend      = 0;
  logic [31:0] pend_data = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Memory model: decides ready/rvalid on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      pend         = 0;
      stall_cnt    = 0;
      mem_rvalid_i = 1'b0;
      mem_ready_i  = 1'b0;
      mem_rdata_i  = '0;
    end else begin
      mem_rvalid_i = 1'b0;
      if (pend) begin
        if (lat_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = pend_data;
          pend         = 0;
        end else begin
          lat_cnt--;
        end
      end
      mem_ready_i = (stall_cnt == 0);
      if (mem_req_o) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
        end else begin
          pend      = 1;
          lat_cnt   = resp_lat - 1;
          pend_data = mem_we_o ? 32'h0 : mem_val(mem_addr_o);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every rvalid pulse.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (if_rvalid_o) begin
        if (sb_if.size() == 0) begin
          total++; bad++;
          $display("FAIL if_rvalid: unexpected pulse data %0h, none required", if_rdata_o);
        end else begin
          e = sb_if.pop_front();
          if (e.chk) check("if_rdata", if_rdata_o, e.data);
        end
      end
      if (lsu_rvalid_o) begin
        if (sb_lsu.size() == 0) begin
          total++; bad++;
          $display("FAIL lsu_rvalid: unexpected pulse data %0h, none required", lsu_rdata_o);
        end else begin
          e = sb_lsu.pop_front();
          if (e.chk) check("lsu_rdata", lsu_rdata_o, e.data);
        end
      end
    end
  end

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic to_check();
    @(negedge clk); #2;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((sb_if.size() + sb_lsu.size()) != 0 && n < max) begin
      to_check();
      n++;
    end
    check(name, 128'(sb_if.size() + sb_lsu.size()), 128'd0);
    sb_if.delete();
    sb_lsu.delete();
  endtask

  typedef struct {
    logic        if_req, if_flush, lsu_req, lsu_we;
    logic [31:0] addr;
    logic        exp_if, exp_lsu;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int n;
    int lsu_wins;
    bit got_if;
    bit lsu_hit;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0040, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0200, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0300, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0400, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0500, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0600, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0700, 1'b0, 1'b0};

    rst = 1'b1;
    if_req_i = 1'b1; if_flush_i = 1'b0; if_addr_i = 32'h8000_0000;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0010;
    lsu_wdata_i = '0; lsu_wstrb_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset state, with requests held high to show grants stay quiet.
    repeat (2) to_check();
    check("rst_pulses", {if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, mem_req_o}, 5'b0);
    check("rst_payload", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, 69'b0);
    check("rst_rdata", {if_rdata_o, lsu_rdata_o}, 64'b0);
    to_drive();
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    to_drive();
    rst = 1'b0;

    // Lone fetch with cycle-exact timing.
    resp_lat = 2;
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000;
    sb_if.push_back('{32'h0000_0013, 1'b1});
    to_check();
    check("lone_gnt_c0", {if_gnt_o, lsu_gnt_o, mem_req_o}, 3'b100);
    to_drive();
    if_req_i = 1'b0; if_addr_i = 32'h1234_5678;
    to_check();
    check("lone_req_c1", mem_req_o, 1'b1);
    check("lone_payload_c1", {mem_we_o, mem_addr_o, mem_wstrb_o}, {1'b0, 32'h8000_0000, 4'h0});
    to_check();
    check("lone_rv_c2", {mem_req_o, if_rvalid_o}, 2'b00);
    to_check();
    check("lone_rv_c3", if_rvalid_o, 1'b1);
    wait_drain("lone_drain", 5);
    to_check();
    check("lone_rdata_hold", {if_rvalid_o, if_rdata_o}, {1'b0, 32'h0000_0013});

    // Arbitration table: one transaction per record.
    for (int i = 0; i < 8; i++) begin
      to_drive();
      if_req_i = vecs[i].if_req; if_flush_i = vecs[i].if_flush;
      if_addr_i = vecs[i].addr;
      lsu_req_i = vecs[i].lsu_req; lsu_we_i = vecs[i].lsu_we;
      lsu_addr_i = vecs[i].addr + 32'h10;
      lsu_wdata_i = ~vecs[i].addr; lsu_wstrb_i = 4'hF;
      if (vecs[i].exp_if) sb_if.push_back('{mem_val(vecs[i].addr), 1'b1});
      if (vecs[i].exp_lsu)
        sb_lsu.push_back('{vecs[i].lsu_we ? 32'h0 : mem_val(vecs[i].addr + 32'h10), !vecs[i].lsu_we});
      to_check();
      check($sformatf("vec%0d_gnt", i), {if_gnt_o, lsu_gnt_o}, {vecs[i].exp_if, vecs[i].exp_lsu});
      to_drive();
      if_req_i = 1'b0; if_flush_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0;
      wait_drain($sformatf("vec%0d_drain", i), 20);
      to_check();
    end

    // Contention: LSU first, IF in the IDLE after the LSU response.
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_2000;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_1000;
    sb_lsu.push_back('{mem_val(32'h8000_1000), 1'b1});
    sb_if.push_back('{mem_val(32'h8000_2000), 1'b1});
    to_check();
    check("cont_first", {if_gnt_o, lsu_gnt_o}, 2'b01);
    to_drive();
    lsu_req_i = 1'b0;
    n = 0;
    do begin
      to_check();
      n++;
    end while (!if_gnt_o && n < 20);
    check("cont_if_gnt_cycle", 128'(n), 128'd4);
    to_drive();
    if_req_i = 1'b0;
    wait_drain("cont_drain", 20);

    // Starvation: LSU held high with IF pending.
    resp_lat = 1;
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_3000;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h8000_4000;
    lsu_wins = 0; got_if = 0;
    for (int cyc = 0; cyc < 80 && !got_if; cyc++) begin
      to_check();
      lsu_hit = lsu_gnt_o;
      if (lsu_gnt_o) begin
        lsu_wins++;
        sb_lsu.push_back('{mem_val(lsu_addr_i), 1'b1});
      end
      if (if_gnt_o) begin
        got_if = 1;
        sb_if.push_back('{mem_val(if_addr_i), 1'b1});
      end
      to_drive();
      if (lsu_hit) lsu_addr_i = lsu_addr_i + 32'h4;
    end
    check("starve_lsu_wins", 128'(lsu_wins), 128'd4);
    check("starve_if_won", got_if, 1'b1);
    if_req_i = 1'b0;
    n = 0;
    do begin
      to_check();
      n++;
    end while (!lsu_gnt_o && n < 20);
    check("starve_lsu_after_if", lsu_gnt_o, 1'b1);
    sb_lsu.push_back('{mem_val(lsu_addr_i), 1'b1});
    to_drive();
    lsu_req_i = 1'b0;
    wait_drain("starve_drain", 20);
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_3100;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h8000_4100;
    sb_lsu.push_back('{mem_val(32'h8000_4100), 1'b1});
    to_check();
    check("starve_cleared", {if_gnt_o, lsu_gnt_o}, 2'b01);
    to_drive();
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    wait_drain("starve_clr_drain", 20);

    // Flush one cycle before the response: no if_rvalid_o.
    resp_lat = 3;
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_5000;
    to_check();
    check("flush_gnt", if_gnt_o, 1'b1);
    to_drive();
    if_req_i = 1'b0;
    to_check();
    to_drive();
    to_check();
    to_drive();
    if_flush_i = 1'b1;
    to_check();
    check("flush_rv_c3", if_rvalid_o, 1'b0);
    to_drive();
    if_flush_i = 1'b0;
    to_check();
    check("flush_rv_c4", if_rvalid_o, 1'b0);
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_5100;
    sb_if.push_back('{mem_val(32'h8000_5100), 1'b1});
    to_check();
    check("flush_next_gnt", if_gnt_o, 1'b1);
    to_drive();
    if_req_i = 1'b0;
    wait_drain("flush_next_drain", 20);

    // Flush in the same cycle as the response.
    resp_lat = 2;
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_5200;
    to_check();
    to_drive();
    if_req_i = 1'b0;
    to_check();
    to_drive();
    to_check();
    to_drive();
    if_flush_i = 1'b1;
    to_check();
    check("flush_same_rv", {if_rvalid_o, if_rdata_o}, {1'b0, mem_val(32'h8000_5100)});
    to_drive();
    if_flush_i = 1'b0;
    to_check();

    // Store with three cycles of backpressure.
    to_drive();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_6000;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wstrb_i = 4'b0011;
    stall_cnt = 3;
    sb_lsu.push_back('{32'h0, 1'b0});
    to_check();
    check("bp_gnt", lsu_gnt_o, 1'b1);
    to_drive();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wstrb_i = '0;
    for (int c = 0; c < 4; c++) begin
      to_check();
      check($sformatf("bp_req_c%0d", c + 1), mem_req_o, 1'b1);
      check($sformatf("bp_payload_c%0d", c + 1), {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o},
            {1'b1, 32'h8000_6000, 32'hDEAD_BEEF, 4'b0011});
    end
    to_check();
    check("bp_req_dropped", mem_req_o, 1'b0);
    wait_drain("bp_drain", 20);

    // Asynchronous reset while stuck in REQ.
    to_drive();
    if_req_i = 1'b1; if_addr_i = 32'h8000_7000;
    stall_cnt = 10;
    to_check();
    check("rstq_gnt", if_gnt_o, 1'b1);
    to_drive();
    #2 rst = 1'b1;
    #1;
    check("rstq_pulses", {if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o, mem_req_o}, 5'b0);
    check("rstq_payload", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, 69'b0);
    check("rstq_rdata", {if_rdata_o, lsu_rdata_o}, 64'b0);
    to_drive();
    to_drive();
    rst = 1'b0;
    if_addr_i = 32'h8000_7100;
    sb_if.push_back('{mem_val(32'h8000_7100), 1'b1});
    to_check();
    check("rstq_regrant", if_gnt_o, 1'b1);
    to_drive();
    if_req_i = 1'b0;
    wait_drain("rstq_drain", 20);

    repeat (3) to_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
